// File: rtl/alu_pkg.sv
// Shared types and encodings for the MIPS ALU and its issue-side controller.
package alu_pkg;

  typedef enum logic [4:0] {
    C_NOP   = 5'd0,
    C_ADDU  = 5'd1,
    C_SUBU  = 5'd2,
    C_MULT  = 5'd3,
    C_MULTU = 5'd4,
    C_AND   = 5'd5,
    C_OR    = 5'd6,
    C_XOR   = 5'd7,
    C_SLL   = 5'd8,
    C_SRL   = 5'd9,
    C_SRA   = 5'd10,
    C_SLT   = 5'd11,
    C_SLTU  = 5'd12,
    C_MFHI  = 5'd13,
    C_MFLO  = 5'd14,
    C_BEQ   = 5'd15,
    C_BNE   = 5'd16,
    C_BLEZ  = 5'd17,
    C_BGTZ  = 5'd18,
    C_BLTZ  = 5'd19,
    C_BGEZ  = 5'd20,
    C_JR    = 5'd21
  } alu_sel_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Multiplies retire into HI/LO instead of the register file.
  function automatic logic is_mul(input alu_sel_t sel);
    return (sel == C_MULT) || (sel == C_MULTU);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational MIPS ALU: arithmetic/logic/shift results, 2*WIDTH products and branch conditions.
module alu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [4:0]       shamt,
  input  alu_sel_t         sel,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             branch_taken
);

  logic [2*WIDTH-1:0] prod_s;
  logic               a_neg_s;
  logic               a_zero_s;

  assign a_neg_s  = reg_a[WIDTH-1];
  assign a_zero_s = (reg_a == {WIDTH{1'b0}});

  // Result, product and branch-condition evaluation for the selected operation.
  always_comb begin
    result       = {WIDTH{1'b0}};
    result_hi    = {WIDTH{1'b0}};
    branch_taken = 1'b0;
    prod_s       = {(2*WIDTH){1'b0}};
    case (sel)
      C_ADDU:  result = reg_a + reg_b;
      C_SUBU:  result = reg_a - reg_b;
      C_MULT: begin
        // Sign-extended operands make the truncated unsigned product the signed one.
        prod_s    = {{WIDTH{reg_a[WIDTH-1]}}, reg_a} * {{WIDTH{reg_b[WIDTH-1]}}, reg_b};
        result    = prod_s[WIDTH-1:0];
        result_hi = prod_s[2*WIDTH-1:WIDTH];
      end
      C_MULTU: begin
        prod_s    = {{WIDTH{1'b0}}, reg_a} * {{WIDTH{1'b0}}, reg_b};
        result    = prod_s[WIDTH-1:0];
        result_hi = prod_s[2*WIDTH-1:WIDTH];
      end
      C_AND:   result = reg_a & reg_b;
      C_OR:    result = reg_a | reg_b;
      C_XOR:   result = reg_a ^ reg_b;
      C_SLL:   result = reg_b << shamt;
      C_SRL:   result = reg_b >> shamt;
      C_SRA:   result = unsigned'($signed(reg_b) >>> shamt);
      C_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(reg_a) < $signed(reg_b))};
      C_SLTU:  result = {{(WIDTH-1){1'b0}}, (reg_a < reg_b)};
      C_BEQ:   branch_taken = (reg_a == reg_b);
      C_BNE:   branch_taken = (reg_a != reg_b);
      C_BLEZ:  branch_taken = a_neg_s | a_zero_s;
      C_BGTZ:  branch_taken = ~a_neg_s & ~a_zero_s;
      C_BLTZ:  branch_taken = a_neg_s;
      C_BGEZ:  branch_taken = ~a_neg_s;
      C_JR:    branch_taken = 1'b1;
      default: result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_issue_decode.sv
// Combinational opcode/funct decode into ALU select and operand/writeback steering flags.
module alu_issue_decode import alu_pkg::*; (
  input  logic [31:0] instr,
  output alu_sel_t    opsel,
  output logic        imm_sext_en,
  output logic        uses_imm,
  output logic        wb_sel_rt,
  output logic        is_branch,
  output logic        illegal
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rt_s;
  logic       unused_fields_s;

  assign op_s            = instr[31:26];
  assign funct_s         = instr[5:0];
  assign rt_s            = instr[20:16];
  assign unused_fields_s = ^{instr[25:21], instr[15:6]};

  // Opcode-level decode; R-type and REGIMM refine on funct and rt.
  always_comb begin
    opsel       = C_NOP;
    imm_sext_en = 1'b0;
    uses_imm    = 1'b0;
    wb_sel_rt   = 1'b0;
    is_branch   = 1'b0;
    illegal     = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADDU:  opsel = C_ADDU;
          FN_SUBU:  opsel = C_SUBU;
          FN_MULT:  opsel = C_MULT;
          FN_MULTU: opsel = C_MULTU;
          FN_AND:   opsel = C_AND;
          FN_OR:    opsel = C_OR;
          FN_XOR:   opsel = C_XOR;
          FN_SLL:   opsel = C_SLL;
          FN_SRL:   opsel = C_SRL;
          FN_SRA:   opsel = C_SRA;
          FN_SLT:   opsel = C_SLT;
          FN_SLTU:  opsel = C_SLTU;
          FN_MFHI:  opsel = C_MFHI;
          FN_MFLO:  opsel = C_MFLO;
          FN_JR: begin
            opsel     = C_JR;
            is_branch = 1'b1;
          end
          default:  illegal = 1'b1;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        imm_sext_en = 1'b1;
        uses_imm    = 1'b1;
        wb_sel_rt   = 1'b1;
        case (op_s)
          OP_ADDIU: opsel = C_ADDU;
          OP_SLTI:  opsel = C_SLT;
          default:  opsel = C_SLTU;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        uses_imm  = 1'b1;
        wb_sel_rt = 1'b1;
        case (op_s)
          OP_ANDI: opsel = C_AND;
          OP_ORI:  opsel = C_OR;
          default: opsel = C_XOR;
        endcase
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        imm_sext_en = 1'b1;
        is_branch   = 1'b1;
        case (op_s)
          OP_BEQ:  opsel = C_BEQ;
          OP_BNE:  opsel = C_BNE;
          OP_BLEZ: opsel = C_BLEZ;
          default: opsel = C_BGTZ;
        endcase
      end
      OP_REGIMM: begin
        imm_sext_en = 1'b1;
        if (rt_s == 5'd0) begin
          opsel     = C_BLTZ;
          is_branch = 1'b1;
        end else if (rt_s == 5'd1) begin
          opsel     = C_BGEZ;
          is_branch = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts a register-read packet, runs one ALU cycle, owns HI/LO and
// presents a registered writeback/branch packet with valid/ready on both sides.
module alu_issue_ctrl import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  input  logic [WIDTH-1:0] in_pc4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_wb_en,
  output logic [4:0]       out_wb_rd,
  output logic [WIDTH-1:0] out_wb_data,
  output logic             out_br_taken,
  output logic [WIDTH-1:0] out_br_target,
  output logic             out_illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  ctrl_state_t      state_r;
  ctrl_state_t      state_nxt_s;
  alu_sel_t         dec_sel_s;
  logic             dec_sext_s;
  logic             dec_uses_imm_s;
  logic             dec_wb_rt_s;
  logic             dec_branch_s;
  logic             dec_illegal_s;
  logic             accept_s;
  logic [WIDTH-1:0] imm_ext_s;
  logic             unused_rs_field_s;

  alu_sel_t         sel_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] imm_ext_r;
  logic [WIDTH-1:0] pc4_r;
  logic [4:0]       shamt_r;
  logic [4:0]       wb_rd_r;
  logic             is_branch_r;
  logic             illegal_r;

  logic [WIDTH-1:0] alu_result_s;
  logic [WIDTH-1:0] alu_result_hi_s;
  logic             alu_taken_s;
  logic [WIDTH-1:0] wb_data_s;
  logic [WIDTH-1:0] target_s;
  logic             writes_s;

  assign in_ready          = (state_r == S_IDLE);
  assign accept_s          = in_valid & in_ready;
  assign unused_rs_field_s = ^in_instr[25:21];
  assign imm_ext_s         = dec_sext_s ? {{(WIDTH-16){in_instr[15]}}, in_instr[15:0]}
                                        : {{(WIDTH-16){1'b0}}, in_instr[15:0]};

  alu_issue_decode u_decode (
    .instr       (in_instr),
    .opsel       (dec_sel_s),
    .imm_sext_en (dec_sext_s),
    .uses_imm    (dec_uses_imm_s),
    .wb_sel_rt   (dec_wb_rt_s),
    .is_branch   (dec_branch_s),
    .illegal     (dec_illegal_s)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .reg_a        (a_r),
    .reg_b        (b_r),
    .shamt        (shamt_r),
    .sel          (sel_r),
    .result       (alu_result_s),
    .result_hi    (alu_result_hi_s),
    .branch_taken (alu_taken_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: accept, one execute cycle, hold response until consumed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_nxt_s = S_EXEC;
        else          state_nxt_s = S_IDLE;
      end
      S_EXEC: state_nxt_s = S_RESP;
      S_RESP: begin
        if (out_ready) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_RESP;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand and decode capture at accept; the ALU sees only these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r       <= C_NOP;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      imm_ext_r   <= {WIDTH{1'b0}};
      pc4_r       <= {WIDTH{1'b0}};
      shamt_r     <= 5'd0;
      wb_rd_r     <= 5'd0;
      is_branch_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (accept_s) begin
      sel_r       <= dec_sel_s;
      a_r         <= in_rs_data;
      b_r         <= dec_uses_imm_s ? imm_ext_s : in_rt_data;
      imm_ext_r   <= imm_ext_s;
      pc4_r       <= in_pc4;
      shamt_r     <= in_instr[10:6];
      wb_rd_r     <= dec_wb_rt_s ? in_instr[20:16] : in_instr[15:11];
      is_branch_r <= dec_branch_s;
      illegal_r   <= dec_illegal_s;
    end else begin
      sel_r <= sel_r;
    end
  end

  // Writeback data source, branch target and register-file write qualification.
  always_comb begin
    wb_data_s = alu_result_s;
    case (sel_r)
      C_MFHI:  wb_data_s = hi;
      C_MFLO:  wb_data_s = lo;
      default: wb_data_s = alu_result_s;
    endcase
    if (sel_r == C_JR) begin
      target_s = a_r;
    end else begin
      target_s = pc4_r + (imm_ext_r << 2'd2);
    end
    writes_s = ~is_branch_r & ~illegal_r & ~is_mul(sel_r) & (wb_rd_r != 5'd0);
  end

  // Result packet and HI/LO update on the execute edge; valid drops on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_wb_en     <= 1'b0;
      out_wb_rd     <= 5'd0;
      out_wb_data   <= {WIDTH{1'b0}};
      out_br_taken  <= 1'b0;
      out_br_target <= {WIDTH{1'b0}};
      out_illegal   <= 1'b0;
      hi            <= {WIDTH{1'b0}};
      lo            <= {WIDTH{1'b0}};
    end else if (state_r == S_EXEC) begin
      out_valid     <= 1'b1;
      out_wb_en     <= writes_s;
      out_wb_rd     <= wb_rd_r;
      out_wb_data   <= wb_data_s;
      out_br_taken  <= alu_taken_s & ~illegal_r;
      out_br_target <= target_s;
      out_illegal   <= illegal_r;
      if (is_mul(sel_r)) begin
        hi <= alu_result_hi_s;
        lo <= alu_result_s;
      end else begin
        hi <= hi;
        lo <= lo;
      end
    end else if ((state_r == S_RESP) && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl against an instruction-level reference model.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        br;
    logic [31:0] tgt;
    logic        ill;
    logic        is_br;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_rs_data = 32'h0;
  logic [31:0] in_rt_data = 32'h0;
  logic [31:0] in_pc4 = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_wb_en;
  logic [4:0]  out_wb_rd;
  logic [31:0] out_wb_data;
  logic        out_br_taken;
  logic [31:0] out_br_target;
  logic        out_illegal;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mhi = 32'h0;
  logic [31:0] mlo = 32'h0;

  logic [5:0] fn_tab [15] = '{6'h21, 6'h23, 6'h18, 6'h19, 6'h24, 6'h25, 6'h26, 6'h00,
                              6'h02, 6'h03, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h08};
  logic [5:0] op_tab [12] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                              6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h01};
  logic [5:0] bad_tab [5] = '{6'h3F, 6'h02, 6'h23, 6'h2B, 6'h0F};

  alu_issue_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_pc4(in_pc4),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en), .out_wb_rd(out_wb_rd),
    .out_wb_data(out_wb_data), .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .out_illegal(out_illegal), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural model of one instruction; updates mhi/mlo for multiplies.
  task automatic model(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] pc4, output exp_t e);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rtf;
    logic [4:0]  sh;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wr;
    longint      p;
    logic [63:0] pu;
    op   = instr[31:26];
    fn   = instr[5:0];
    rtf  = instr[20:16];
    sh   = instr[10:6];
    simm = {{16{instr[15]}}, instr[15:0]};
    zimm = {16'h0, instr[15:0]};
    e    = '0;
    e.tgt = pc4 + simm * 32'd4;
    res  = 32'h0;
    dst  = instr[15:11];
    wr   = 1'b0;
    case (op)
      6'h00: begin
        wr = 1'b1;
        case (fn)
          6'h21: res = rs + rt;
          6'h23: res = rs - rt;
          6'h24: res = rs & rt;
          6'h25: res = rs | rt;
          6'h26: res = rs ^ rt;
          6'h00: res = rt << sh;
          6'h02: res = rt >> sh;
          6'h03: res = 32'($signed(rt) >>> sh);
          6'h2A: res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
          6'h2B: res = (rs < rt) ? 32'd1 : 32'd0;
          6'h10: res = mhi;
          6'h12: res = mlo;
          6'h18: begin
            wr = 1'b0;
            p = longint'(signed'(rs)) * longint'(signed'(rt));
            mhi = p[63:32];
            mlo = p[31:0];
          end
          6'h19: begin
            wr = 1'b0;
            pu = {32'h0, rs} * {32'h0, rt};
            mhi = pu[63:32];
            mlo = pu[31:0];
          end
          6'h08: begin
            wr = 1'b0;
            e.is_br = 1'b1;
            e.br = 1'b1;
            e.tgt = rs;
          end
          default: begin
            wr = 1'b0;
            e.ill = 1'b1;
          end
        endcase
      end
      6'h09: begin wr = 1'b1; dst = rtf; res = rs + simm; end
      6'h0A: begin wr = 1'b1; dst = rtf; res = ($signed(rs) < $signed(simm)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = 1'b1; dst = rtf; res = (rs < simm) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; dst = rtf; res = rs & zimm; end
      6'h0D: begin wr = 1'b1; dst = rtf; res = rs | zimm; end
      6'h0E: begin wr = 1'b1; dst = rtf; res = rs ^ zimm; end
      6'h04: begin e.is_br = 1'b1; e.br = (rs == rt); end
      6'h05: begin e.is_br = 1'b1; e.br = (rs != rt); end
      6'h06: begin e.is_br = 1'b1; e.br = ($signed(rs) <= 0); end
      6'h07: begin e.is_br = 1'b1; e.br = ($signed(rs) > 0); end
      6'h01: begin
        if (rtf == 5'd0) begin e.is_br = 1'b1; e.br = ($signed(rs) < 0); end
        else if (rtf == 5'd1) begin e.is_br = 1'b1; e.br = ($signed(rs) >= 0); end
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    e.wb_en = wr && (dst != 5'd0);
    e.rd    = dst;
    e.data  = res;
  endtask

  // Full transaction: issue, latency/field checks, optional stall, handshake.
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] pc4, input int stall, output exp_t e);
    logic [159:0] snap;
    model(instr, rs, rt, pc4, e);
    @(negedge clk);
    check_val("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_instr = instr; in_rs_data = rs; in_rt_data = rt; in_pc4 = pc4;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_instr = $urandom; in_rs_data = $urandom; in_rt_data = $urandom; in_pc4 = $urandom;
    @(negedge clk);
    check_val("valid_early", out_valid, 1'b0);
    check_val("in_ready_exec", in_ready, 1'b0);
    @(negedge clk);
    check_val("valid_lat2", out_valid, 1'b1);
    check_val("illegal", out_illegal, e.ill);
    check_val("br_taken", out_br_taken, e.br);
    check_val("wb_en", out_wb_en, e.wb_en);
    if (e.wb_en) begin
      check_val("wb_rd", out_wb_rd, e.rd);
      check_val("wb_data", out_wb_data, e.data);
    end
    if (e.is_br) check_val("br_target", out_br_target, e.tgt);
    check_val("hi", hi, mhi);
    check_val("lo", lo, mlo);
    snap = {out_wb_en, out_wb_rd, out_wb_data, out_br_taken, out_br_target, out_illegal, hi, lo};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_val("stall_hold", {out_wb_en, out_wb_rd, out_wb_data, out_br_taken, out_br_target,
                               out_illegal, hi, lo}, snap);
      check_val("stall_valid", out_valid, 1'b1);
      check_val("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_val("ready_after_hs", in_ready, 1'b1);
    check_val("valid_after_hs", out_valid, 1'b0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] r;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    int          k;

    #12;
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_outs", {out_valid, out_wb_en, out_br_taken, out_illegal, out_wb_rd}, 9'd0);
    check_val("rst_data", {out_wb_data, out_br_target, hi, lo}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addu rd=3
    run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd5, 32'd7, 32'h40, 0, e);
    check_val("addu_const", e.data, 32'd12);
    // multu / mult / mfhi
    run_instr({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h19}, 32'hFFFFFFFE, 32'd3, 32'h44, 1, e);
    check_val("multu_hilo", {hi, lo}, 64'h00000002_FFFFFFFA);
    run_instr({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h18}, 32'hFFFFFFFE, 32'd3, 32'h48, 0, e);
    check_val("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_instr({6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h10}, 32'h1234, 32'h5678, 32'h4C, 0, e);
    check_val("mfhi_const", out_wb_data, 32'hFFFFFFFF);
    // immediates and branch
    run_instr({6'h09, 5'd1, 5'd2, 16'hFFFF}, 32'd1, 32'h99, 32'h50, 0, e);
    run_instr({6'h0D, 5'd0, 5'd2, 16'hFFFF}, 32'd0, 32'h99, 32'h54, 0, e);
    run_instr({6'h04, 5'd9, 5'd9, 16'h0004}, 32'h55, 32'h55, 32'h100, 0, e);
    check_val("beq_target_const", out_br_target, 32'h110);
    // long stall, illegal, rd=0
    run_instr({6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h23}, 32'd100, 32'd1, 32'h58, 5, e);
    run_instr({6'h3F, 26'h1234567}, 32'h1, 32'h2, 32'h5C, 0, e);
    run_instr({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21}, 32'd5, 32'd7, 32'h60, 0, e);

    // async reset while a mult is executing
    @(negedge clk);
    in_valid = 1'b1; in_instr = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h18};
    in_rs_data = 32'h7; in_rt_data = 32'h9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid", out_valid, 1'b0);
    check_val("rst_mid_hilo", {hi, lo}, 64'd0);
    check_val("rst_mid_ready", in_ready, 1'b1);
    mhi = 32'h0;
    mlo = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd5, 32'd7, 32'h64, 0, e);

    // randomized mix, including illegal encodings
    for (int n = 0; n < 200; n++) begin
      r = $urandom;
      k = $urandom_range(0, 31);
      if (k < 15) begin
        instr = {6'h00, r[25:6], fn_tab[k]};
      end else if (k < 27) begin
        instr = {op_tab[k-15], r[25:0]};
        if (op_tab[k-15] == 6'h01) instr[20:16] = 5'($urandom_range(0, 2));
      end else if (k < 30) begin
        instr = {bad_tab[$urandom_range(0, 4)], r[25:0]};
      end else begin
        instr = {6'h00, r[25:6], 6'h01};
      end
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 5))
        0: rs = 32'h0;
        1: rt = rs;
        2: rs = 32'h80000000;
        3: rs = 32'($urandom_range(0, 3));
        default: rs = rs;
      endcase
      run_instr(instr, rs, rt, $urandom & 32'hFFFFFFFC, $urandom_range(0, 3), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
